mod_counter_chain: RTL and testbench
====================================

# mod_counter_chain

Parametrised cascade of N modulo counters with per-stage moduli, run-time up/down direction, synchronous parallel load and an optional stop-at-terminal mode. It generalises the single modulo counter and hand-chained sec/min/hr counters into one block. Stage 0 is least significant, and each stage's carry/borrow enables the next stage. It sits wherever the design needs a timer, a time-of-day counter or a mixed-radix event counter.

## Interface
- N, 4, number of stages (≥1)
- W, 8, field width per stage; every M[i] ≤ 2**W
- M, '{10,60,60,24}, int array [N], modulus of stage i (M[0] = stage 0); each ≥2
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset; synchronous and active-high
- en  in  1  count enable for stage 0
- dir  in  1  0 = count up, 1 = count down
- load  in  1  synchronous parallel load strobe
- load_val  in  [N-1:0][W-1:0]  value loaded into each stage
- stop  in  1  0 = wrap mode, 1 = stop-at-terminal mode
- cnt  out  [N-1:0][W-1:0]  stage values, cnt[i] < M[i]
- co  out  [N-1:0]  per-stage carry (up) or borrow (down), combinational
- tc  out  1  chain terminal count, equal to co[N-1]
- done  out  1  sticky: chain reached its terminal value in stop mode

## Operation
- Stage enables:
  - se[0] = en & ~done
  - se[i] = co[i-1] for i ≥ 1
- Terminal condition per stage:
  - up: term[i] = (cnt[i] == M[i]-1)
  - down: term[i] = (cnt[i] == 0)
- co[i] = se[i] & term[i]. co and tc are combinational from cnt, en, dir and done, with no register stage.
- Stage update when se[i] is high:
  - up: cnt[i] becomes cnt[i]+1, or 0 if term[i]
  - down: cnt[i] becomes cnt[i]-1, or M[i]-1 if term[i]
  - Stage values hold when se[i] is low.
- Priority each cycle: rst > load > hold-at-terminal > count.
- Load: cnt[i] becomes load_val[i]. A load_val[i] ≥ M[i] is clamped to M[i]-1. Load also clears done. Load ignores en, stop and done.
- Stop mode (stop=1):
  - If tc=1, no stage updates, so the chain holds the terminal value: all stages M[i]-1 when counting up, all zero when counting down.
  - done is set on the next edge.
  - While done=1, se[0]=0, so co and tc are 0 and the chain is frozen regardless of dir or en.
  - Only rst or load clears done.
- Wrap mode (stop=0): tc pulses for one cycle and the whole chain wraps. done is never set. If stop falls while done=1, done stays 1 until load or rst.
- Changing dir takes effect in the same cycle, because term, co and the next value all use the current dir.
- Arithmetic is modulo M[i] within W bits. No value outside 0..M[i]-1 is ever produced.

## Timing
- Reset values: cnt = all 0, done = 0. Consequently co = 0 and tc = 0 unless en=1 with dir=1, in which case the combinational borrow chain is active from all-zero.
- Count latency: 1 cycle from the en sample to the cnt change.
- Carry ripple is combinational across all N stages in one cycle. A full-chain wrap completes on a single edge.
- load, rst and done take effect on the edge where they are sampled.
- load and tc in the same cycle: load wins and done stays 0.
- rst during load, during count or while done=1 returns everything to reset values.

## Test plan
- Defaults (N=4, M={10,60,60,24}), en=1, dir=0, stop=0, run from reset for 864000 cycles:
  - cnt={0,0,0,0} again at the end
  - tc pulses exactly once, on the cycle where cnt={9,59,59,23}
  - co[0] pulses every 10 cycles
- Load load_val={5,70,3,2}, dir=1, en=1:
  - next cnt={5,59,3,2} (field 1 clamped from 70 to 59)
  - after 6 more cycles cnt={9,58,3,2}; the borrow from 0 makes stage 0 wrap to 9
- stop=1, dir=0, load {8,59,59,23}:
  - after 1 cycle tc=1
  - next cycle done=1 and cnt holds {9,59,59,23} for 20 cycles; co stays 0
  - toggling dir does not unfreeze the chain
  - a load of {0,0,0,0} clears done and counting resumes
- stop=1, dir=1, from reset with en=1:
  - tc=1 immediately, done=1 after 1 edge, cnt stays {0,0,0,0}
- en toggling 1/0 every cycle: stage 0 advances only on en=1 cycles; all co are 0 when en=0.
- Assert rst mid-count, with the chain wrapping and load asserted in the same cycle: next cnt={0,0,0,0} and done=0.

Source files
------------

// File: rtl/mod_counter_chain.sv
// mod_counter_chain: cascade of N modulo counters with per-stage moduli,
// up/down direction, synchronous parallel load and stop-at-terminal mode.
// Stage 0 is least significant; each stage's carry/borrow enables the next.
module mod_counter_chain #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned M [N] = '{10, 60, 60, 24}
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_dir,
  input  logic                  i_load,
  input  logic [N-1:0][W-1:0]   i_load_val,
  input  logic                  i_stop,
  output logic [N-1:0][W-1:0]   o_cnt,
  output logic [N-1:0]          o_co,
  output logic                  o_tc,
  output logic                  o_done
);

  localparam int unsigned WL = W + 1;

  logic [N-1:0][W-1:0] r_cnt;
  logic                r_done;
  logic [N-1:0][W-1:0] w_nxt;
  logic [N-1:0][W-1:0] w_ld;
  logic [N-1:0]        w_co;
  logic                w_tc;

  // Ripple the enable through all stages in one cycle and form next values
  always_comb begin : p_chain
    logic v_en;
    logic v_term;
    logic v_co;
    w_nxt = r_cnt;
    w_ld  = '0;
    w_co  = '0;
    v_en  = i_en & ~r_done;
    for (int i = 0; i < int'(N); i++) begin
      v_term = i_dir ? (r_cnt[i] == '0) : (r_cnt[i] == W'(M[i] - 1));
      v_co   = v_en & v_term;
      w_co[i] = v_co;
      if (v_en) begin
        if (i_dir) begin
          w_nxt[i] = v_term ? W'(M[i] - 1) : (r_cnt[i] - W'(1));
        end else begin
          w_nxt[i] = v_term ? '0 : (r_cnt[i] + W'(1));
        end
      end
      // out-of-range load values clamp to the stage maximum
      w_ld[i] = ({1'b0, i_load_val[i]} >= WL'(M[i])) ? W'(M[i] - 1) : i_load_val[i];
      v_en = v_co;
    end
  end

  assign w_tc = w_co[N-1];

  // State update: reset > load > hold-at-terminal > count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= w_ld;
      r_done <= 1'b0;
    end else if (i_stop && w_tc) begin
      r_done <= 1'b1;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = r_done;
  assign o_co   = w_co;
  assign o_tc   = w_tc;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Self-checking bench for mod_counter_chain with default parameters.
module tb_mod_counter_chain;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic                i_clk = 1'b0;
  logic                i_rst, i_en, i_dir, i_load, i_stop;
  logic [N-1:0][W-1:0] i_load_val;
  logic [N-1:0][W-1:0] o_cnt;
  logic [N-1:0]        o_co;
  logic                o_tc, o_done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic                rst, load, en, dir, stop;
    logic [N-1:0][W-1:0] lv;
    logic [N-1:0]        co;      // expected before the edge
    logic                tc;
    logic [N-1:0][W-1:0] cnt;     // expected after the edge
    logic                done;
  } vec_t;

  vec_t vecs[$];

  mod_counter_chain #(.N(N), .W(W), .M('{10, 60, 60, 24})) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_dir(i_dir), .i_load(i_load),
    .i_load_val(i_load_val), .i_stop(i_stop),
    .o_cnt(o_cnt), .o_co(o_co), .o_tc(o_tc), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [N-1:0][W-1:0] c4(int s0, int s1, int s2, int s3);
    logic [N-1:0][W-1:0] v;
    v[0] = W'(s0); v[1] = W'(s1); v[2] = W'(s2); v[3] = W'(s3);
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(logic rst, logic load, logic [N-1:0][W-1:0] lv, logic en,
                     logic dir, logic stop, logic [N-1:0] co, logic tc,
                     logic [N-1:0][W-1:0] cnt, logic done);
    vec_t v;
    v.rst = rst; v.load = load; v.lv = lv; v.en = en; v.dir = dir; v.stop = stop;
    v.co = co; v.tc = tc; v.cnt = cnt; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic drive(logic rst, logic load, logic [N-1:0][W-1:0] lv,
                       logic en, logic dir, logic stop);
    @(negedge i_clk);
    i_rst = rst; i_load = load; i_load_val = lv; i_en = en; i_dir = dir; i_stop = stop;
    #1;
  endtask

  initial begin
    logic [N-1:0][W-1:0] z;
    int co0_n, co1_n, tc_n, last_co0;
    z = '0;
    i_rst = 1'b1; i_load = 1'b0; i_load_val = '0; i_en = 1'b0; i_dir = 1'b0; i_stop = 1'b0;

    //   rst load lv                 en dir stop co       tc   cnt after           done
    add(1, 0, z,                  0, 0, 0, 4'b0000, 0, c4(0,0,0,0),   0);
    add(0, 1, c4(5,70,3,2),       1, 1, 0, 4'b1111, 1, c4(5,59,3,2),   0);
    add(0, 0, z,                  1, 1, 0, 4'b0000, 0, c4(4,59,3,2),   0);
    add(0, 0, z,                  1, 1, 0, 4'b0000, 0, c4(3,59,3,2),   0);
    add(0, 0, z,                  1, 1, 0, 4'b0000, 0, c4(2,59,3,2),   0);
    add(0, 0, z,                  1, 1, 0, 4'b0000, 0, c4(1,59,3,2),   0);
    add(0, 0, z,                  1, 1, 0, 4'b0000, 0, c4(0,59,3,2),   0);
    add(0, 0, z,                  1, 1, 0, 4'b0001, 0, c4(9,58,3,2),   0);
    add(0, 1, c4(8,59,59,23),     1, 0, 1, 4'b0001, 0, c4(8,59,59,23), 0);
    add(0, 0, z,                  1, 0, 1, 4'b0000, 0, c4(9,59,59,23), 0);
    add(0, 0, z,                  1, 0, 1, 4'b1111, 1, c4(9,59,59,23), 1);
    add(0, 0, z,                  1, 0, 1, 4'b0000, 0, c4(9,59,59,23), 1);
    add(0, 0, z,                  1, 1, 1, 4'b0000, 0, c4(9,59,59,23), 1);
    add(0, 0, z,                  1, 1, 0, 4'b0000, 0, c4(9,59,59,23), 1);
    add(0, 1, z,                  1, 0, 1, 4'b0000, 0, c4(0,0,0,0),   0);
    add(0, 0, z,                  1, 0, 1, 4'b0000, 0, c4(1,0,0,0),   0);
    add(0, 0, z,                  0, 0, 1, 4'b0000, 0, c4(1,0,0,0),   0);
    add(0, 0, z,                  1, 0, 1, 4'b0000, 0, c4(2,0,0,0),   0);
    add(0, 0, z,                  0, 1, 1, 4'b0000, 0, c4(2,0,0,0),   0);
    add(0, 0, z,                  1, 1, 0, 4'b0000, 0, c4(1,0,0,0),   0);
    add(0, 0, z,                  1, 1, 0, 4'b0000, 0, c4(0,0,0,0),   0);
    add(0, 0, z,                  1, 1, 0, 4'b1111, 1, c4(9,59,59,23), 0);
    add(0, 0, z,                  1, 0, 0, 4'b1111, 1, c4(0,0,0,0),   0);
    add(1, 1, c4(1,2,3,4),        1, 1, 1, 4'b1111, 1, c4(0,0,0,0),   0);
    add(0, 0, z,                  1, 1, 1, 4'b1111, 1, c4(0,0,0,0),   1);
    add(0, 0, z,                  1, 1, 1, 4'b0000, 0, c4(0,0,0,0),   1);
    add(1, 0, z,                  0, 0, 0, 4'b0000, 0, c4(0,0,0,0),   0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].load, vecs[k].lv, vecs[k].en, vecs[k].dir, vecs[k].stop);
      chk("co", k, 32'(o_co), 32'(vecs[k].co));
      chk("tc", k, 32'(o_tc), 32'(vecs[k].tc));
      @(posedge i_clk); #1;
      chk("cnt", k, 32'(o_cnt), 32'(vecs[k].cnt));
      chk("done", k, 32'(o_done), 32'(vecs[k].done));
    end

    // Free-running up count from reset: carry cadence and ripple into upper stages
    co0_n = 0; co1_n = 0; tc_n = 0; last_co0 = -1;
    for (int c = 0; c < 1000; c++) begin
      drive(0, 0, z, 1, 0, 0);
      if (o_co[0]) begin
        co0_n++;
        chk("co0_phase", c, 32'(c % 10), 32'd9);
        if (last_co0 >= 0) chk("co0_gap", c, 32'(c - last_co0), 32'd10);
        last_co0 = c;
      end
      if (o_co[1]) co1_n++;
      if (o_tc) tc_n++;
      @(posedge i_clk);
    end
    #1;
    chk("run_co0_count", 0, 32'(co0_n), 32'd100);
    chk("run_co1_count", 0, 32'(co1_n), 32'd1);
    chk("run_tc_count", 0, 32'(tc_n), 32'd0);
    chk("run_cnt", 0, 32'(o_cnt), 32'(c4(0,40,1,0)));

    // Full-chain wrap from near the top: single tc pulse at {9,59,59,23}
    drive(0, 1, c4(0,59,59,23), 1, 0, 0);
    @(posedge i_clk);
    tc_n = 0;
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, z, 1, 0, 0);
      if (o_tc) begin
        tc_n++;
        chk("wrap_tc_cnt", c, 32'(o_cnt), 32'(c4(9,59,59,23)));
      end
      @(posedge i_clk);
    end
    #1;
    chk("wrap_tc_count", 0, 32'(tc_n), 32'd1);
    chk("wrap_cnt", 0, 32'(o_cnt), 32'(c4(0,0,0,0)));
    chk("wrap_done", 0, 32'(o_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
